// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle shift-add multiplier and restoring divider writing HI/LO.
// Optional feature macro MULDIV_EARLY_OUT_EN: multiplies stop after the multiplier's significant bits.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [0:WIDTH-1] busA,
    input  logic [0:WIDTH-1] busB,
    output logic             busy,
    output logic             done,
    output logic [0:WIDTH-1] hi,
    output logic [0:WIDTH-1] lo,
    output logic             divByZero
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

`ifdef MULDIV_EARLY_OUT_EN
    function automatic logic [CW-1:0] mul_iters(input logic [WIDTH-1:0] m);
        logic [CW-1:0] n;
        n = CW'(1);
        for (int i = 0; i < WIDTH; i++)
            if (m[i]) n = CW'(i + 1);
        return n;
    endfunction
`endif

    logic [WIDTH-1:0] a_in, b_in;
    assign a_in = busA;
    assign b_in = busB;

    state_t           state_q;
    logic             busy_q, done_q, dbz_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [CW-1:0]    cnt_q;

    logic [W2-1:0]    acc_q, mcand_q;
    logic [WIDTH-1:0] shf_q, rem_q, dvsr_q, araw_q;
    logic             div_q, zero_q, negp_q, negr_q;

    logic             is_div, a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [CW-1:0]    n_start;

    always_comb begin
        is_div  = op[1];
        a_neg   = op[0] & a_in[WIDTH-1];
        b_neg   = op[0] & b_in[WIDTH-1];
        a_mag   = mag(a_in, a_neg);
        b_mag   = mag(b_in, b_neg);
        b_zero  = (b_in == '0);
        n_start = CW'(WIDTH);
        // Divide by zero takes a single dummy step so done lands two cycles after start.
        if (is_div && b_zero) n_start = CW'(1);
`ifdef MULDIV_EARLY_OUT_EN
        if (!is_div) n_start = mul_iters(b_mag);
`endif
    end

    logic [W2-1:0]    acc_d, mcand_d, prod;
    logic [WIDTH-1:0] shf_d, rem_d, quo, rmd, hi_res, lo_res;
    logic [WIDTH:0]   shifted, trial;

    always_comb begin
        acc_d   = acc_q + (shf_q[0] ? mcand_q : '0);
        mcand_d = mcand_q << 1;
        shifted = {rem_q, shf_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvsr_q};
        if (div_q) begin
            // shf_q holds the dividend shifting out at the top and quotient bits entering at the bottom.
            shf_d = {shf_q[WIDTH-2:0], ~trial[WIDTH]};
            rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        end else begin
            shf_d = shf_q >> 1;
            rem_d = rem_q;
        end
        prod = negp_q ? -acc_d : acc_d;
        quo  = mag(shf_d, negp_q);
        rmd  = mag(rem_d, negr_q);
        if (zero_q) begin
            hi_res = araw_q;
            lo_res = '1;
        end else if (div_q) begin
            hi_res = rmd;
            lo_res = quo;
        end else begin
            hi_res = prod[W2-1:WIDTH];
            lo_res = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && start) begin
            acc_q   <= '0;
            mcand_q <= {{WIDTH{1'b0}}, a_mag};
            shf_q   <= is_div ? a_mag : b_mag;
            rem_q   <= '0;
            dvsr_q  <= b_mag;
            araw_q  <= a_in;
            div_q   <= is_div;
            zero_q  <= is_div & b_zero;
            negp_q  <= a_neg ^ b_neg;
            negr_q  <= a_neg;
        end else if (state_q == S_RUN) begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            shf_q   <= shf_d;
            rem_q   <= rem_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        dbz_q   <= 1'b0;
                        cnt_q   <= n_start;
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        hi_q    <= hi_res;
                        lo_q    <= lo_res;
                        dbz_q   <= zero_q;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign divByZero = dbz_q;
endmodule
